// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared encodings and helpers for the bus arbiter
//
// Purpose: FSM state codes, bus-mux master-select codes, slave id constants,
//          address split for slave decode, and small decode helpers.
// Ports:   none (package).
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M1 = 2'd1,
    GNT_M2 = 2'd2,
    ERR    = 2'd3
  } arb_state_t;

  // bus-mux master select codes
  localparam logic [1:0] BM_NONE = 2'd0;
  localparam logic [1:0] BM_M1   = 2'd1;
  localparam logic [1:0] BM_M2   = 2'd2;

  // slave id encoding as carried on m*_slave_id
  localparam logic [1:0] SLV1        = 2'd0;
  localparam logic [1:0] SLV2        = 2'd1;
  localparam logic [1:0] SLV3        = 2'd2;
  localparam logic [1:0] SLV_INVALID = 2'd3;

  // slave id is the two address bits ending at this position (addr[13:12])
  localparam int SLAVE_ID_MSB = 13;

  // One-hot slave enable for a slave id; the invalid id decodes to no slave.
  function automatic logic [2:0] slave_onehot(input logic [1:0] id);
    logic [2:0] sel;
    sel = 3'b000;
    case (id)
      SLV1:    sel = 3'b001;
      SLV2:    sel = 3'b010;
      SLV3:    sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

  // A master may be granted only when it requests a valid, ready slave.
  function automatic logic is_eligible(input logic       request,
                                       input logic [1:0] id,
                                       input logic [2:0] ready);
    return request && ((slave_onehot(id) & ready) != 3'b000);
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// rtl/arb_timeout_cnt.sv - grant-hold counter with clear/enable and expiry flag
//
// Purpose: counts cycles of the current grant; expired is high once the
//          count has reached TIMEOUT-1. The count saturates there so a long
//          uncontested grant can still be preempted later. TIMEOUT=0 never
//          expires.
// Ports:
//   clk     in  system clock, rising edge
//   reset   in  synchronous active-low reset
//   clear   in  force count to zero (priority over enable)
//   enable  in  advance the count by one
//   expired out count has reached the preemption point
module arb_timeout_cnt #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Saturation point; with preemption disabled the counter just parks at all-ones.
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '1 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master system bus arbiter with slave-ready check and grant timeout
//
// Purpose: grants the shared bus to master 1 or master 2 when its target
//          slave is valid and ready, drives the bus-mux select and one-hot
//          slave select, pulses an error for invalid slave ids, and preempts
//          a grant held for TIMEOUT cycles while the other master waits.
// Config:  BUS_ARB_ROUND_ROBIN_EN - ties go to the master not granted most
//          recently; without it master 1 wins every tie.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-low reset
//   m1_request   in   master 1 request, held for the whole transaction
//   m2_request   in   master 2 request
//   m1_slave_id  in   master 1 target (0..2 = slave1..3, 3 = invalid)
//   m2_slave_id  in   master 2 target
//   slave_ready  in   bit i: slave i+1 can accept a transaction
//   m1_grant     out  master 1 owns the bus
//   m2_grant     out  master 2 owns the bus
//   bus_master   out  mux select 0=none 1=m1 2=m2
//   slave_sel    out  one-hot slave enable, latched at grant time
//   m1_err       out  one-cycle pulse, master 1 requested invalid slave
//   m2_err       out  one-cycle pulse, master 2 requested invalid slave
//   state_out    out  current FSM state (debug)
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic [1:0] m1_slave_id,
  input  logic [1:0] m2_slave_id,
  input  logic [2:0] slave_ready,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic [1:0] bus_master,
  output logic [2:0] slave_sel,
  output logic       m1_err,
  output logic       m2_err,
  output logic [1:0] state_out
);

  arb_state_t state, next_state;

  logic [1:0] pending, pending_next;     // master owed the bus after a preemption
  logic [2:0] sel_latch, sel_latch_next; // slave select frozen for the grant
  logic [1:0] err_flags, err_flags_next; // {m2,m1} to report while in ERR
  logic [1:0] armed, armed_next;         // {m2,m1} may still raise an error
  logic [1:0] pick;                      // master chosen in IDLE this cycle
  logic [1:0] tie_pick;
  logic       m1_elig, m2_elig;
  logic       m1_bad, m2_bad;            // requesting the invalid id
  logic       m1_inv, m2_inv;            // invalid and not yet reported
  logic       preempt;
  logic       cnt_clear, cnt_enable, cnt_expired;

  logic       m1_grant_d, m2_grant_d, m1_err_d, m2_err_d;
  logic [1:0] bus_master_d;
  logic [2:0] slave_sel_d;

  assign m1_elig = is_eligible(m1_request, m1_slave_id, slave_ready);
  assign m2_elig = is_eligible(m2_request, m2_slave_id, slave_ready);
  assign m1_bad  = m1_request && (m1_slave_id == SLV_INVALID);
  assign m2_bad  = m2_request && (m2_slave_id == SLV_INVALID);
  assign m1_inv  = m1_bad && armed[0];
  assign m2_inv  = m2_bad && armed[1];

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic last_m2; // 1: master 2 was granted most recently

  assign tie_pick = last_m2 ? BM_M1 : BM_M2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_m2 <= 1'b1;
    end else if (pick == BM_M1) begin
      last_m2 <= 1'b0;
    end else if (pick == BM_M2) begin
      last_m2 <= 1'b1;
    end
  end
`else
  assign tie_pick = BM_M1;
`endif

  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  assign cnt_enable = (state == GNT_M1) || (state == GNT_M2);
  assign state_out  = state;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pending    <= BM_NONE;
      sel_latch  <= 3'b000;
      err_flags  <= 2'b00;
      armed      <= 2'b11;
      m1_grant   <= 1'b0;
      m2_grant   <= 1'b0;
      bus_master <= BM_NONE;
      slave_sel  <= 3'b000;
      m1_err     <= 1'b0;
      m2_err     <= 1'b0;
    end else begin
      state      <= next_state;
      pending    <= pending_next;
      sel_latch  <= sel_latch_next;
      err_flags  <= err_flags_next;
      armed      <= armed_next;
      m1_grant   <= m1_grant_d;
      m2_grant   <= m2_grant_d;
      bus_master <= bus_master_d;
      slave_sel  <= slave_sel_d;
      m1_err     <= m1_err_d;
      m2_err     <= m2_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state     = state;
    pending_next   = pending;
    sel_latch_next = sel_latch;
    err_flags_next = 2'b00;
    pick           = BM_NONE;
    preempt        = 1'b0;
    cnt_clear      = 1'b1;

    // A pending claim is dropped once its master stops asking for the bus,
    // so it cannot jump the queue on some later unrelated request.
    if ((pending == BM_M1) && !m1_request) pending_next = BM_NONE;
    if ((pending == BM_M2) && !m2_request) pending_next = BM_NONE;

    unique case (state)
      IDLE: begin
        if ((pending == BM_M1) && m1_elig)      pick = BM_M1;
        else if ((pending == BM_M2) && m2_elig) pick = BM_M2;
        else if (m1_elig && m2_elig)            pick = tie_pick;
        else if (m1_elig)                       pick = BM_M1;
        else if (m2_elig)                       pick = BM_M2;

        if (pick == BM_M1) begin
          next_state     = GNT_M1;
          sel_latch_next = slave_onehot(m1_slave_id);
        end else if (pick == BM_M2) begin
          next_state     = GNT_M2;
          sel_latch_next = slave_onehot(m2_slave_id);
        end else if (m1_inv || m2_inv) begin
          next_state     = ERR;
          err_flags_next = {m2_inv, m1_inv};
        end

        if ((pick != BM_NONE) && (pick == pending)) pending_next = BM_NONE;
      end
      GNT_M1: begin
        preempt   = cnt_expired && m2_elig;
        cnt_clear = !m1_request || preempt;
        if (cnt_clear) next_state = IDLE;
        // pending is recorded even when the owner releases on the same edge
        if (preempt) pending_next = BM_M2;
      end
      GNT_M2: begin
        preempt   = cnt_expired && m1_elig;
        cnt_clear = !m2_request || preempt;
        if (cnt_clear) next_state = IDLE;
        if (preempt) pending_next = BM_M1;
      end
      ERR: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    // An invalid request reports once; it re-arms when the request drops or
    // the id moves off the invalid value.
    armed_next[0] = err_flags_next[0] ? 1'b0 : (!m1_bad ? 1'b1 : armed[0]);
    armed_next[1] = err_flags_next[1] ? 1'b0 : (!m2_bad ? 1'b1 : armed[1]);
  end

  // Output decode of the current state, registered above, so grants follow
  // the state register by one cycle and both grants can never overlap.
  always_comb begin
    m1_grant_d   = (state == GNT_M1);
    m2_grant_d   = (state == GNT_M2);
    bus_master_d = BM_NONE;
    slave_sel_d  = 3'b000;
    m1_err_d     = (state == ERR) && err_flags[0];
    m2_err_d     = (state == ERR) && err_flags[1];
    if (state == GNT_M1) begin
      bus_master_d = BM_M1;
      slave_sel_d  = sel_latch;
    end else if (state == GNT_M2) begin
      bus_master_d = BM_M2;
      slave_sel_d  = sel_latch;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter with reference model
module tb_bus_arbiter;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       m1_request = 1'b0, m2_request = 1'b0;
  logic [1:0] m1_slave_id = 2'd0, m2_slave_id = 2'd0;
  logic [2:0] slave_ready = 3'b111;
  logic       m1_grant, m2_grant, m1_err, m2_err;
  logic [1:0] bus_master, state_out;
  logic [2:0] slave_sel;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .m1_request(m1_request), .m2_request(m2_request),
    .m1_slave_id(m1_slave_id), .m2_slave_id(m2_slave_id),
    .slave_ready(slave_ready),
    .m1_grant(m1_grant), .m2_grant(m2_grant),
    .bus_master(bus_master), .slave_sel(slave_sel),
    .m1_err(m1_err), .m2_err(m2_err), .state_out(state_out)
  );

  logic [9:0] obs;
  assign obs = {m1_grant, m2_grant, bus_master, slave_sel, m1_err, m2_err};

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, how long, who is owed it, and the
  // bus view that becomes visible one cycle after each decision.
  int         own, hold, pend, last;
  bit         erring;
  bit   [1:0] err_who, armed;
  logic [2:0] own_sel;
  logic [9:0] expv;

  function automatic bit elig(bit r, logic [1:0] id, logic [2:0] rdy);
    logic [3:0] r4;
    r4 = {1'b0, rdy};
    return r && (id != 2'd3) && r4[id];
  endfunction

  task automatic model_update();
    bit el1, el2, bad1, bad2, rel, pre, new_err;
    int pick;
    if (!reset) begin
      expv = '0; own = 0; hold = 0; pend = 0; last = 2;
      erring = 0; err_who = 0; armed = 2'b11; own_sel = 3'b000;
      return;
    end
    expv = {own == 1, own == 2, 2'(own), (own != 0) ? own_sel : 3'b000,
            erring && err_who[0], erring && err_who[1]};
    el1  = elig(m1_request, m1_slave_id, slave_ready);
    el2  = elig(m2_request, m2_slave_id, slave_ready);
    bad1 = m1_request && (m1_slave_id == 2'd3);
    bad2 = m2_request && (m2_slave_id == 2'd3);
    new_err = 0;
    if (pend == 1 && !m1_request) pend = 0;
    if (pend == 2 && !m2_request) pend = 0;
    if (own != 0) begin
      rel = (own == 1) ? !m1_request : !m2_request;
      pre = (TIMEOUT != 0) && (hold >= TIMEOUT - 1) && ((own == 1) ? el2 : el1);
      if (pre) pend = 3 - own;
      if (rel || pre) begin own = 0; hold = 0; end
      else hold++;
    end else if (erring) begin
      erring = 0;
    end else begin
      pick = 0;
      if (pend == 1 && el1)      pick = 1;
      else if (pend == 2 && el2) pick = 2;
      else if (el1 && el2)       pick = RR ? 3 - last : 1;
      else if (el1)              pick = 1;
      else if (el2)              pick = 2;
      if (pick != 0) begin
        own = pick; hold = 0; last = pick;
        own_sel = 3'b001 << ((pick == 1) ? m1_slave_id : m2_slave_id);
        if (pend == pick) pend = 0;
      end else if ((bad1 && armed[0]) || (bad2 && armed[1])) begin
        erring = 1; new_err = 1;
        err_who = {bad2 && armed[1], bad1 && armed[0]};
      end
    end
    armed[0] = (new_err && err_who[0]) ? 1'b0 : (!bad1 ? 1'b1 : armed[0]);
    armed[1] = (new_err && err_who[1]) ? 1'b0 : (!bad2 ? 1'b1 : armed[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(bit r1, logic [1:0] i1, bit r2, logic [1:0] i2, logic [2:0] rdy);
    m1_request = r1; m1_slave_id = i1;
    m2_request = r2; m2_slave_id = i2;
    slave_ready = rdy;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 3'b111);
    step(); step();
    checks++; if (obs !== 10'd0) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 10'd0); end
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    checks++; if (obs !== expv) begin errors++; $display("FAIL reset_model: got %b expected %b", obs, expv); end
    reset = 1'b1;
    step();
    checks++; if (obs !== 10'd0) begin errors++; $display("FAIL reset_release_idle: got %b expected %b", obs, 10'd0); end
  endtask

  task automatic test_single_grant();
    drive(1, 0, 0, 0, 3'b111);
    step();
    checks++; if (m1_grant !== 1'b0) begin errors++; $display("FAIL single_latency: got %b expected 0", m1_grant); end
    step();
    checks++; if ({m1_grant, bus_master, slave_sel} !== {1'b1, 2'd1, 3'b001})
      begin errors++; $display("FAIL single_grant: got %b expected %b", {m1_grant, bus_master, slave_sel}, {1'b1, 2'd1, 3'b001}); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (obs !== expv) begin errors++; $display("FAIL single_hold cyc%0d: got %b expected %b", c, obs, expv); end
    end
    drive(0, 0, 0, 0, 3'b111);
    step(); step();
    checks++; if (obs !== 10'd0) begin errors++; $display("FAIL single_release: got %b expected %b", obs, 10'd0); end
  endtask

  task automatic test_tie();
    bit winner_m2;
    drive(1, 1, 1, 2, 3'b111);
    step(); step();
    checks++; if ({m1_grant, m2_grant, slave_sel} !== {2'b10, 3'b010})
      begin errors++; $display("FAIL tie_first: got %b expected %b", {m1_grant, m2_grant, slave_sel}, {2'b10, 3'b010}); end
    drive(0, 1, 0, 2, 3'b111);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (obs !== expv) begin errors++; $display("FAIL tie_drop cyc%0d: got %b expected %b", c, obs, expv); end
    end
    drive(1, 1, 1, 2, 3'b111);
    step(); step();
    winner_m2 = RR;
    checks++; if ({m1_grant, m2_grant} !== (winner_m2 ? 2'b01 : 2'b10))
      begin errors++; $display("FAIL tie_second: got %b expected %b", {m1_grant, m2_grant}, winner_m2 ? 2'b01 : 2'b10); end
    if (winner_m2) drive(1, 1, 0, 2, 3'b111); else drive(0, 1, 1, 2, 3'b111);
    step(); step();
    checks++; if ({m1_grant, m2_grant, bus_master} !== 4'b0000)
      begin errors++; $display("FAIL tie_turnaround: got %b expected 0000", {m1_grant, m2_grant, bus_master}); end
    step();
    checks++; if ({m1_grant, m2_grant, slave_sel} !== (winner_m2 ? {2'b10, 3'b010} : {2'b01, 3'b100}))
      begin errors++; $display("FAIL tie_handoff: got %b expected %b", {m1_grant, m2_grant, slave_sel}, winner_m2 ? {2'b10, 3'b010} : {2'b01, 3'b100}); end
    drive(0, 0, 0, 0, 3'b111);
    step(); step(); step();
  endtask

  task automatic test_timeout();
    int m2_cycles, gap;
    bit got_m1;
    drive(0, 0, 1, 2, 3'b111);
    step(); step();
    checks++; if (m2_grant !== 1'b1) begin errors++; $display("FAIL timeout_start: got %b expected 1", m2_grant); end
    drive(1, 0, 1, 2, 3'b111);
    m2_cycles = 1; gap = 0; got_m1 = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++; if (obs !== expv) begin errors++; $display("FAIL timeout_model cyc%0d: got %b expected %b", c, obs, expv); end
      if (!got_m1) begin
        if (m2_grant) m2_cycles++;
        else if (m1_grant) got_m1 = 1;
        else gap++;
      end
    end
    checks++; if (m2_cycles != TIMEOUT) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", m2_cycles, TIMEOUT); end
    checks++; if (gap != 1) begin errors++; $display("FAIL timeout_gap: got %0d expected 1", gap); end
    checks++; if (!got_m1) begin errors++; $display("FAIL timeout_handoff: got 0 expected 1"); end
    drive(0, 0, 0, 0, 3'b111);
    step(); step(); step();
  endtask

  task automatic test_invalid();
    int pulses, grants;
    drive(1, 3, 0, 0, 3'b111);
    pulses = 0; grants = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (obs !== expv) begin errors++; $display("FAIL invalid_model cyc%0d: got %b expected %b", c, obs, expv); end
      pulses += int'(m1_err);
      grants += int'(m1_grant | m2_grant);
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL invalid_pulses: got %0d expected 1", pulses); end
    checks++; if (grants != 0) begin errors++; $display("FAIL invalid_nogrant: got %0d expected 0", grants); end
    drive(1, 2, 0, 0, 3'b111);
    step(); step();
    checks++; if ({m1_grant, slave_sel} !== 4'b1100)
      begin errors++; $display("FAIL invalid_recover: got %b expected 1100", {m1_grant, slave_sel}); end
    drive(0, 0, 0, 0, 3'b111);
    step(); step(); step();
  endtask

  task automatic test_not_ready();
    int seen;
    drive(1, 1, 0, 0, 3'b101);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      seen += int'(m1_grant | m2_grant | m1_err | m2_err);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL notready_wait: got %0d active cycles expected 0", seen); end
    drive(1, 1, 0, 0, 3'b111);
    step(); step();
    checks++; if ({m1_grant, slave_sel} !== 4'b1010)
      begin errors++; $display("FAIL notready_grant: got %b expected 1010", {m1_grant, slave_sel}); end
  endtask

  task automatic test_reset_mid_grant();
    reset = 1'b0;
    step();
    checks++; if ({obs, state_out} !== 12'd0) begin errors++; $display("FAIL midreset_clear: got %b expected 0", {obs, state_out}); end
    reset = 1'b1;
    step();
    checks++; if (m1_grant !== 1'b0) begin errors++; $display("FAIL midreset_latency: got %b expected 0", m1_grant); end
    step();
    checks++; if ({m1_grant, slave_sel} !== 4'b1010)
      begin errors++; $display("FAIL midreset_regrant: got %b expected 1010", {m1_grant, slave_sel}); end
    drive(0, 0, 0, 0, 3'b111);
    step(); step(); step();
  endtask

  task automatic test_random();
    bit r1, r2;
    logic [1:0] i1, i2;
    logic [2:0] rdy;
    r1 = 0; r2 = 0; i1 = 0; i2 = 0; rdy = 3'b111;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 11) == 0) r1 = !r1;
      if ($urandom_range(0, 11) == 0) r2 = !r2;
      if ($urandom_range(0, 15) == 0) i1 = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) i2 = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 9) == 0) rdy[b] = !rdy[b];
      reset = ($urandom_range(0, 299) != 0);
      drive(r1, i1, r2, i2, rdy);
      step();
      checks++; if (obs !== expv) begin errors++; $display("FAIL random cyc%0d: got %b expected %b", c, obs, expv); end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_tie();
    test_timeout();
    test_invalid();
    test_not_ready();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
